// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver: preamble hunt, LSB-first payload, 0/1/0 trailer check
// Optional FRAME_RX_REPEAT_CHECK_EN: present a good word only when it repeats the previous good word.
module serial_frame_rx #(
   parameter int DATA_W       = 5,
   parameter int PREAMBLE_LEN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              serial_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_err,
   output logic              locked
);
   localparam int ONES_W = $clog2(PREAMBLE_LEN + 1);
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam logic [ONES_W-1:0] C_ONES_SAT = ONES_W'(PREAMBLE_LEN);
   localparam logic [ONES_W-1:0] C_ONES_ONE = ONES_W'(1);
   localparam logic [BIT_W-1:0]  C_BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_HUNT, S_DATA, S_TRAIL} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_in_q;
   logic [ONES_W-1:0]   r_ones_cnt, w_ones_nxt;
   logic [BIT_W-1:0]    r_bit_cnt, w_bit_nxt;
   logic [1:0]          r_trl_cnt, w_trl_nxt;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   r_data_out;
   logic                r_data_valid, r_frame_err, r_locked;
   logic                w_trl_ok, w_good, w_err, w_present;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_q     <= 1'b1;
         r_state    <= S_HUNT;
         r_ones_cnt <= '0;
         r_bit_cnt  <= '0;
         r_trl_cnt  <= '0;
         r_shift    <= '0;
      end else begin
         r_in_q     <= serial_in;
         r_state    <= w_state_nxt;
         r_ones_cnt <= w_ones_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_trl_cnt  <= w_trl_nxt;
         if (r_state == S_DATA)
            r_shift[r_bit_cnt] <= r_in_q;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ones_nxt  = r_ones_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_trl_nxt   = r_trl_cnt;
      case (r_state)
         S_HUNT: begin
            if (r_in_q) begin
               if (r_ones_cnt != C_ONES_SAT)
                  w_ones_nxt = r_ones_cnt + C_ONES_ONE;
            end else if (r_ones_cnt == C_ONES_SAT) begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = '0;
               w_ones_nxt  = '0;
            end else begin
               w_ones_nxt  = '0;
            end
         end
         S_DATA: begin
            if (r_bit_cnt == C_BIT_LAST) begin
               w_state_nxt = S_TRAIL;
               w_trl_nxt   = '0;
            end else begin
               w_bit_nxt   = r_bit_cnt + 1'b1;
            end
         end
         S_TRAIL: begin
            // A wrong trailer bit is fed straight back into the preamble hunt.
            if (!w_trl_ok) begin
               w_state_nxt = S_HUNT;
               w_ones_nxt  = r_in_q ? C_ONES_ONE : '0;
            end else if (r_trl_cnt == 2'd2) begin
               w_state_nxt = S_HUNT;
               w_ones_nxt  = '0;
            end else begin
               w_trl_nxt   = r_trl_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_HUNT;
      endcase
   end

`ifdef FRAME_RX_REPEAT_CHECK_EN
   logic [DATA_W-1:0] r_prev;
   logic              r_prev_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev     <= '0;
         r_prev_vld <= 1'b0;
      end else if (w_err) begin
         r_prev_vld <= 1'b0;
      end else if (w_good) begin
         r_prev     <= r_shift;
         r_prev_vld <= 1'b1;
      end
   end
`endif

   always_comb begin
      w_trl_ok  = (r_in_q == (r_trl_cnt == 2'd1));
      w_err     = (r_state == S_TRAIL) && !w_trl_ok;
      w_good    = (r_state == S_TRAIL) && w_trl_ok && (r_trl_cnt == 2'd2);
`ifdef FRAME_RX_REPEAT_CHECK_EN
      w_present = w_good && r_prev_vld && (r_prev == r_shift);
`else
      w_present = w_good;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_data_valid <= w_present;
         r_frame_err  <= w_err;
         if (w_present)
            r_data_out <= r_shift;
         if (w_err)
            r_locked <= 1'b0;
         else if (w_good)
            r_locked <= 1'b1;
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign frame_err  = r_frame_err;
   assign locked     = r_locked;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx against a frame-level reference model
module tb_serial_frame_rx;
   localparam int DATA_W    = 5;
   localparam int PRE       = 4;
   localparam int FRAME_LEN = PRE + 1 + DATA_W + 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              serial_in = 1'b1;
   logic [DATA_W-1:0] data_out;
   logic              data_valid, frame_err, locked;

   serial_frame_rx #(.DATA_W(DATA_W), .PREAMBLE_LEN(PRE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int t;
      int err;
      int d;
   } ev_t;

   ev_t obs_q[$];
   ev_t exp_q[$];
   int  bits_q[$];
   int  base_cyc = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   int  exp_locked, exp_dout;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         ev_t e;
         if (data_valid) begin
            e.t = cyc; e.err = 0; e.d = int'(data_out);
            obs_q.push_back(e);
         end
         if (frame_err) begin
            e.t = cyc; e.err = 1; e.d = 0;
            obs_q.push_back(e);
         end
         if (data_valid && frame_err) chk("valid_err_exclusive", 1, 0);
      end
   end

   task automatic send_bit(input int b);
      @(posedge clk);
      #1;
      serial_in = b[0];
      if (bits_q.size() == 0) base_cyc = cyc;
      bits_q.push_back(b & 1);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_bit((s[i] == 8'h31) ? 1 : 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1);
   endtask

   // trl is written in wire order: bit 2 goes first
   task automatic send_frame(input int payload, input int trl);
      send_str("11110");
      for (int i = 0; i < DATA_W; i++) send_bit((payload >> i) & 1);
      for (int i = 0; i < 3; i++) send_bit((trl >> (2 - i)) & 1);
   endtask

   task automatic start_seg();
      obs_q.delete();
      bits_q.delete();
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      serial_in = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_seg();
   endtask

   // Scan the bit history from reset: find a 0 preceded by PRE ones inside the
   // current hunt window, take the payload, then judge the trailer.
   function automatic void run_model();
      int n = bits_q.size();
      int hs = 0;
      int prev = 0;
      int prev_vld = 0;
      exp_q.delete();
      exp_locked = 0;
      exp_dout = 0;
      for (int p = 0; p + DATA_W + 3 < n; p++) begin
         int   run_ok, payload, q, present;
         ev_t  e;
         if (p - hs < PRE || bits_q[p] != 0) continue;
         run_ok = 1;
         for (int k = 1; k <= PRE; k++) if (bits_q[p-k] != 1) run_ok = 0;
         if (run_ok == 0) continue;
         payload = 0;
         for (int k = 0; k < DATA_W; k++) payload |= bits_q[p+1+k] << k;
         q = -1;
         for (int k = 0; k < 3; k++)
            if (q < 0 && bits_q[p+1+DATA_W+k] != ((k == 1) ? 1 : 0)) q = p + 1 + DATA_W + k;
         if (q >= 0) begin
            e.t = base_cyc + q + 2; e.err = 1; e.d = 0;
            exp_q.push_back(e);
            prev_vld = 0;
            exp_locked = 0;
            hs = (bits_q[q] == 1) ? q : q + 1;
         end else begin
`ifdef FRAME_RX_REPEAT_CHECK_EN
            present = (prev_vld == 1 && prev == payload) ? 1 : 0;
`else
            present = 1;
`endif
            prev = payload;
            prev_vld = 1;
            exp_locked = 1;
            if (present == 1) begin
               e.t = base_cyc + p + DATA_W + 3 + 2; e.err = 0; e.d = payload;
               exp_q.push_back(e);
               exp_dout = payload;
            end
            hs = p + DATA_W + 4;
         end
         p = hs - 1;
      end
   endfunction

   task automatic compare(input string name);
      int m;
      run_model();
      chk({name, "_num_events"}, obs_q.size(), exp_q.size());
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s_ev%0d_cycle", name, i), obs_q[i].t, exp_q[i].t);
         chk($sformatf("%s_ev%0d_kind", name, i), obs_q[i].err, exp_q[i].err);
         chk($sformatf("%s_ev%0d_data", name, i), obs_q[i].d, exp_q[i].d);
      end
      chk({name, "_locked"}, locked, exp_locked);
      chk({name, "_data_out"}, data_out, exp_dout);
   endtask

   function automatic int count_kind(input int err);
      int c = 0;
      foreach (obs_q[i]) if (obs_q[i].err == err) c++;
      return c;
   endfunction

   initial begin
      int last_pl, pl, trl, r;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_data_out", data_out, 0);
      chk("reset_data_valid", data_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_locked", locked, 0);

      do_reset(1);
      send_str("1111001101010");
      idle(12);
      compare("t1");
      chk("t1_err_count", count_kind(1), 0);
`ifdef FRAME_RX_REPEAT_CHECK_EN
      chk("t1_valid_count", count_kind(0), 0);
`else
      chk("t1_valid_count", count_kind(0), 1);
      chk("t1_dout", data_out, 'h16);
`endif
      chk("t1_locked", locked, 1);

      do_reset(2);
      for (int i = 0; i < 3; i++) send_frame('h0B, 3'b010);
      idle(12);
      compare("t2");
`ifdef FRAME_RX_REPEAT_CHECK_EN
      chk("t2_valid_count", count_kind(0), 2);
`else
      chk("t2_valid_count", count_kind(0), 3);
`endif
      for (int i = 1; i < obs_q.size(); i++)
         chk($sformatf("t2_gap%0d", i), obs_q[i].t - obs_q[i-1].t, FRAME_LEN);

      do_reset(2);
      send_frame('h05, 3'b010);
      idle(2);
      send_frame('h0A, 3'b000);
      idle(3);
      chk("t3_locked_after_err", locked, 0);
`ifdef FRAME_RX_REPEAT_CHECK_EN
      chk("t3_dout_held", data_out, 0);
`else
      chk("t3_dout_held", data_out, 'h05);
`endif
      send_frame('h1F, 3'b010);
      idle(12);
      compare("t3");
      chk("t3_err_count", count_kind(1), 1);

      do_reset(2);
      send_str("0110");
      send_frame('h01, 3'b010);
      idle(12);
      compare("t4");
      chk("t4_err_count", count_kind(1), 0);
`ifndef FRAME_RX_REPEAT_CHECK_EN
      chk("t4_dout", data_out, 'h01);
`endif

      start_seg();
      send_str("1111010");
      rst_n = 1'b0;
      #1;
      chk("t5_async_locked", locked, 0);
      chk("t5_async_dout", data_out, 0);
      chk("t5_cut_events", obs_q.size(), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start_seg();
      send_frame('h13, 3'b010);
      idle(12);
      compare("t5");

      do_reset(2);
      idle(100);
      compare("t6");
      chk("t6_locked", locked, 0);

      do_reset(2);
      idle(4);
      last_pl = 0;
      for (int f = 0; f < 200; f++) begin
         r = $urandom_range(0, 7);
         if (r == 0) send_str("110");
         else if (r == 1) for (int k = 0; k < 3; k++) send_bit($urandom_range(0, 1));
         else if (r < 4) idle($urandom_range(1, 3));
         pl  = ($urandom_range(0, 1) == 1) ? last_pl : $urandom_range(0, (1 << DATA_W) - 1);
         trl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : 3'b010;
         send_frame(pl, trl);
         last_pl = pl;
      end
      idle(14);
      compare("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
